systolic_drain: RTL and testbench

Output stage directly downstream of the systolic array and its load/MAC controller. It counts MAC cycles until the array's accumulators have settled, then snapshots all `size*size` PE accumulators in one cycle. It streams the snapshot out row-major over a val/rdy interface, saturating each result to the output width. Completion is signalled with `done`.

---
 rtl/systolic_pkg.sv | 16 +
 rtl/systolic_sat.sv | 34 +++
 rtl/systolic_drain.sv | 124 ++++++++++++
 tb/tb_systolic_drain.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_pkg.sv
// Shared types and defaults for the systolic array drain stage.
package systolic_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } drain_state_t;

  // Accumulators are final once the last operand wavefront has crossed the array.
  function automatic int DRAIN_SETTLE_DEFAULT(input int size);
    return 3 * size - 2;
  endfunction

endpackage

// File: rtl/systolic_sat.sv
// Signed width->owidth saturator with clip flag; purely combinational, no backpressure.
module systolic_sat #(
  parameter int width  = 32,
  parameter int owidth = 16
) (
  input  logic [width-1:0]  acc_i,
  output logic [owidth-1:0] res_o,
  output logic              sat_o
);

  if (owidth == width) begin : g_pass
    assign res_o = acc_i;
    assign sat_o = 1'b0;
  end else begin : g_clip
    logic                    sign;
    logic [width-owidth-1:0] upper;
    logic                    over_hi;
    logic                    over_lo;

    // The value fits only when every bit above the output sign equals the input sign.
    assign sign    = acc_i[width-1];
    assign upper   = acc_i[width-2:owidth-1];
    assign over_hi = !sign && (|upper);
    assign over_lo = sign && !(&upper);
    assign sat_o   = over_hi | over_lo;

    always_comb begin
      res_o = acc_i[owidth-1:0];
      if (over_hi) res_o = {1'b0, {(owidth-1){1'b1}}};
      if (over_lo) res_o = {1'b1, {(owidth-1){1'b0}}};
    end
  end

endmodule

// File: rtl/systolic_drain.sv
// Snapshots the PE accumulators after `settle` MAC cycles and streams them row-major, saturated.
// First beat follows the settle-th mac_en edge; one beat per cycle, outputs hold while send_rdy=0.
module systolic_drain
  import systolic_pkg::*;
#(
  parameter int size   = 4,
  parameter int width  = 32,
  parameter int owidth = 16,
  parameter int settle = DRAIN_SETTLE_DEFAULT(size)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         mac_en,
  input  logic                         clear,
  input  logic [size*size*width-1:0]   pe_acc,
  output logic                         send_val,
  input  logic                         send_rdy,
  output logic [owidth-1:0]            send_msg,
  output logic [$clog2(size)-1:0]      send_row,
  output logic [$clog2(size)-1:0]      send_col,
  output logic                         send_last,
  output logic                         send_sat,
  output logic                         busy,
  output logic                         done
);

  localparam int N  = size * size;
  localparam int IW = $clog2(N);
  localparam int RW = $clog2(size);
  localparam int CW = $clog2(settle);
  localparam logic [CW-1:0] CNT_LAST = CW'(settle - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(N - 1);

  drain_state_t       state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [IW-1:0]      idx_q, idx_d;
  logic [N*width-1:0] snap_q;
  logic               capture;
  logic               in_send;
  logic [width-1:0]   sel_acc;
  logic [owidth-1:0]  sat_res;
  logic               sat_flag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
    end
  end

  // Snapshot buffer carries no reset; it is only read after a capture.
  always_ff @(posedge clk) begin
    if (capture) snap_q <= pe_acc;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (mac_en) begin
          state_d = WAIT;
          cnt_d   = CW'(1);
        end
      end
      WAIT: begin
        if (!mac_en) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          capture = 1'b1;
          idx_d   = '0;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SEND: begin
        if (send_rdy) begin
          if (idx_q == IDX_LAST) state_d = DONE;
          else                   idx_d   = idx_q + 1'b1;
        end
      end
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    if (clear) begin
      state_d = IDLE;
      cnt_d   = '0;
      idx_d   = '0;
      capture = 1'b0;
    end
  end

  assign in_send = (state_q == SEND);
  assign sel_acc = snap_q[idx_q*width +: width];

  systolic_sat #(
    .width (width),
    .owidth(owidth)
  ) u_sat (
    .acc_i(sel_acc),
    .res_o(sat_res),
    .sat_o(sat_flag)
  );

  // Every beat field is masked to zero outside SEND.
  assign send_val  = in_send;
  assign send_msg  = in_send ? sat_res : '0;
  assign send_sat  = in_send & sat_flag;
  assign send_row  = in_send ? RW'(idx_q / size) : '0;
  assign send_col  = in_send ? RW'(idx_q % size) : '0;
  assign send_last = in_send && (idx_q == IDX_LAST);
  assign busy      = (state_q == WAIT) || in_send;
  assign done      = (state_q == DONE);

endmodule

// File: tb/tb_systolic_drain.sv
// Self-checking bench for systolic_drain (size=4, width=32, owidth=16, settle=10).
module tb_systolic_drain;

  localparam int SETTLE = 10;

  typedef struct {
    longint      acc;
    logic [15:0] msg;
    logic        sat;
  } vec_t;

  logic         clk = 1'b0;
  logic         rst_n, mac_en, clear, send_rdy;
  logic [511:0] pe_acc;
  logic         send_val, send_last, send_sat, busy, done;
  logic [15:0]  send_msg;
  logic [1:0]   send_row, send_col;

  int n_checks = 0;
  int n_fail   = 0;

  longint      acc_v[16];
  logic [15:0] exp_msg[16];
  logic        exp_sat[16];
  vec_t        tbl[8];

  systolic_drain dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .mac_en   (mac_en),
    .clear    (clear),
    .pe_acc   (pe_acc),
    .send_val (send_val),
    .send_rdy (send_rdy),
    .send_msg (send_msg),
    .send_row (send_row),
    .send_col (send_col),
    .send_last(send_last),
    .send_sat (send_sat),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference saturation from plain signed arithmetic.
  task automatic sat_model(input longint a, output logic [15:0] m, output logic s);
    if (a > 32767) begin
      m = 16'h7FFF; s = 1'b1;
    end else if (a < -32768) begin
      m = 16'h8000; s = 1'b1;
    end else begin
      m = a[15:0]; s = 1'b0;
    end
  endtask

  task automatic model_all();
    for (int i = 0; i < 16; i++) sat_model(acc_v[i], exp_msg[i], exp_sat[i]);
  endtask

  task automatic set_acc();
    for (int i = 0; i < 16; i++) pe_acc[i*32 +: 32] = acc_v[i][31:0];
  endtask

  // mode 0: rdy always high, 1: alternating 1,0, 2: random.
  task automatic run_drain(input int mode, input int snap_at, input int rst_at, input bit clr_last);
    int n, beats, cyc;
    bit got, stalled;
    logic [15:0] h_msg;
    logic        h_sat, h_last;
    logic [1:0]  h_row, h_col;
    logic [15:0] b_msg[16];
    logic        b_sat[16];
    logic        b_last[16];
    logic [1:0]  b_row[16];
    logic [1:0]  b_col[16];
    set_acc();
    mac_en = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 40) begin
      tick();
      n++;
      got = (send_val === 1'b1);
    end
    chk("settle_edges", n, SETTLE);
    if (!got) begin
      mac_en = 1'b0;
      return;
    end
    beats = 0; cyc = 0; stalled = 1'b0;
    while (beats < 16 && cyc < 200) begin
      mac_en = 1'($urandom_range(0, 1));
      case (mode)
        0:       send_rdy = 1'b1;
        1:       send_rdy = (cyc % 2 == 0);
        default: send_rdy = 1'($urandom_range(0, 1));
      endcase
      if (rst_at == beats) begin
        mac_en = 1'b0; send_rdy = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("rst_val", send_val, 0);
        chk("rst_busy", busy, 0);
        chk("rst_msg", send_msg, 0);
        chk("rst_last", send_last, 0);
        #1 rst_n = 1'b1;
        return;
      end
      clear = clr_last && (beats == 15) && send_rdy;
      if (send_val !== 1'b1) begin
        chk("val_held", send_val, 1);
        break;
      end
      if (stalled) begin
        chk("stall_msg", send_msg, h_msg);
        chk("stall_sat", send_sat, h_sat);
        chk("stall_rc", {send_row, send_col}, {h_row, h_col});
        chk("stall_last", send_last, h_last);
      end
      h_msg = send_msg; h_sat = send_sat; h_row = send_row; h_col = send_col; h_last = send_last;
      if (send_rdy) begin
        b_msg[beats] = send_msg; b_sat[beats] = send_sat; b_last[beats] = send_last;
        b_row[beats] = send_row; b_col[beats] = send_col;
        beats++;
        stalled = 1'b0;
      end else begin
        stalled = 1'b1;
      end
      if (beats == snap_at) begin
        for (int i = 0; i < 16; i++) pe_acc[i*32 +: 32] = 32'hDEAD;
      end
      tick();
      cyc++;
    end
    clear = 1'b0; send_rdy = 1'b0; mac_en = 1'b0;
    chk("beat_count", beats, 16);
    if (mode == 0) chk("send_cycles_full_rate", cyc, 16);
    else if (mode == 1) chk("send_cycles_alternating", cyc, 31);
    if (clr_last) begin
      chk("clr_last_done", done, 0);
      chk("clr_last_busy", busy, 0);
    end else begin
      chk("done_after_last", done, 1);
      chk("val_after_last", send_val, 0);
      chk("busy_after_last", busy, 0);
    end
    for (int i = 0; i < beats; i++) begin
      chk($sformatf("msg[%0d]", i), b_msg[i], exp_msg[i]);
      chk($sformatf("sat[%0d]", i), b_sat[i], exp_sat[i]);
      chk($sformatf("row[%0d]", i), b_row[i], i / 4);
      chk($sformatf("col[%0d]", i), b_col[i], i % 4);
      chk($sformatf("last[%0d]", i), b_last[i], (i == 15));
    end
  endtask

  initial begin
    tbl[0] = '{acc: 40000,  msg: 16'h7FFF, sat: 1'b1};
    tbl[1] = '{acc: -40000, msg: 16'h8000, sat: 1'b1};
    tbl[2] = '{acc: -5,     msg: 16'hFFFB, sat: 1'b0};
    tbl[3] = '{acc: 32767,  msg: 16'h7FFF, sat: 1'b0};
    tbl[4] = '{acc: 32768,  msg: 16'h7FFF, sat: 1'b1};
    tbl[5] = '{acc: -32768, msg: 16'h8000, sat: 1'b0};
    tbl[6] = '{acc: -32769, msg: 16'h8000, sat: 1'b1};
    tbl[7] = '{acc: 0,      msg: 16'h0000, sat: 1'b0};

    rst_n = 1'b0; mac_en = 1'b0; clear = 1'b0; send_rdy = 1'b0; pe_acc = '0;
    #12;
    chk("reset_val", send_val, 0);
    chk("reset_last", send_last, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_msg", send_msg, 0);
    chk("reset_row", send_row, 0);
    chk("reset_col", send_col, 0);
    chk("reset_sat", send_sat, 0);
    rst_n = 1'b1;
    tick();

    // Nominal ramp.
    for (int i = 0; i < 16; i++) acc_v[i] = i;
    model_all();
    run_drain(0, -1, -1, 1'b0);

    // DONE ignores mac_en, then clear returns to IDLE.
    mac_en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("done_holds", done, 1);
    end
    mac_en = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_done", done, 0);
    chk("clear_busy", busy, 0);
    tick();

    // Alternating backpressure.
    for (int i = 0; i < 16; i++) acc_v[i] = 100 * i - 700;
    model_all();
    run_drain(1, -1, -1, 1'b0);
    clear = 1'b1; tick(); clear = 1'b0;

    // Saturation table in slots 0..7.
    for (int i = 0; i < 16; i++) acc_v[i] = (i < 8) ? tbl[i].acc : -(longint'(i) * 3000);
    model_all();
    for (int i = 0; i < 8; i++) begin
      exp_msg[i] = tbl[i].msg;
      exp_sat[i] = tbl[i].sat;
    end
    run_drain(0, -1, -1, 1'b0);
    clear = 1'b1; tick(); clear = 1'b0;

    // Snapshot isolation: inputs overwritten mid-stream.
    for (int i = 0; i < 16; i++) acc_v[i] = i * 7 + 3;
    model_all();
    run_drain(2, 5, -1, 1'b0);
    clear = 1'b1; tick(); clear = 1'b0;

    // Abort in WAIT at cnt=5, then a full settle is required again.
    mac_en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("abort_wait_busy", busy, 1);
      chk("abort_wait_val", send_val, 0);
    end
    mac_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_idle_busy", busy, 0);
      chk("abort_idle_val", send_val, 0);
    end
    for (int i = 0; i < 16; i++) acc_v[i] = 15 - i;
    model_all();
    run_drain(0, -1, -1, 1'b0);
    clear = 1'b1; tick(); clear = 1'b0;

    // Asynchronous reset at beat 7, quiet until a fresh mac_en.
    for (int i = 0; i < 16; i++) acc_v[i] = longint'(int'($urandom));
    model_all();
    run_drain(0, -1, 7, 1'b0);
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("post_rst_val", send_val, 0);
      chk("post_rst_busy", busy, 0);
    end
    run_drain(2, -1, -1, 1'b0);
    clear = 1'b1; tick(); clear = 1'b0;

    // Clear in WAIT wins over mac_en.
    mac_en = 1'b1;
    tick(); tick(); tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_wait_busy", busy, 0);
    for (int i = 0; i < 16; i++) acc_v[i] = -longint'(i) * 5000;
    model_all();
    run_drain(0, -1, -1, 1'b0);
    clear = 1'b1; tick(); clear = 1'b0;

    // Clear on the last handshake: beat accepted, IDLE not DONE.
    run_drain(0, -1, -1, 1'b1);
    tick();
    chk("clr_last_idle_done", done, 0);

    // Random accumulators and random ready.
    for (int r = 0; r < 6; r++) begin
      for (int i = 0; i < 16; i++) begin
        if (i % 2 == 0) acc_v[i] = longint'($urandom_range(0, 80000)) - 40000;
        else            acc_v[i] = longint'(int'($urandom));
      end
      model_all();
      run_drain(2, -1, -1, 1'b0);
      clear = 1'b1; tick(); clear = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
